sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
Shares one synchronous single-port SRAM between the CPU instruction-fetch requester and the data (load/store) requester. Grants one access per cycle, gives priority to data with a bounded-starvation guarantee for fetch, and steers the one-cycle-later read data back to its owner with a valid pulse. Sits between the mips core request ports and the unified memory port at the top level.

Parameters:
STARVE_MAX, 4, max consecutive data grants issued while inst_req is pending before fetch is forced to win (legal range 1..15).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
inst_req  input  1  fetch request; held with inst_addr stable until inst_gnt
inst_addr  input  32  fetch byte address
inst_gnt  output  1  combinational: fetch accepted this cycle
inst_rvalid  output  1  registered: inst_rdata valid this cycle
inst_rdata  output  32  fetch data
data_req  input  1  data request; held with addr/wen/wdata stable until data_gnt
data_wen  input  4  byte write enables; 4'b0000 = read
data_addr  input  32  data byte address
data_wdata  input  32  store data
data_gnt  output  1  combinational: data access accepted this cycle
data_rvalid  output  1  registered: read data or write ack this cycle
data_rdata  output  32  load data (0 for write ack)
sram_en  output  1  SRAM enable
sram_wen  output  4  SRAM byte write enables
sram_addr  output  32  SRAM address
sram_wdata  output  32  SRAM write data
sram_rdata  input  32  SRAM read data, valid cycle after sram_en

Behaviour:
- Reset (async, rst=1): starve counter=0, owner=NONE, inst_rvalid=data_rvalid=0; while held, inst_gnt=data_gnt=0, sram_en=0, sram_wen=0. Response pending at reset is dropped, never delivered.
- Grant (combinational, each cycle, rst=0):
  - only inst_req -> inst_gnt=1.
  - only data_req -> data_gnt=1.
  - both -> data_gnt=1 unless starve_cnt==STARVE_MAX, then inst_gnt=1.
  - neither -> no grant; sram_en=0.
  - Never both grants in one cycle.
- SRAM drive: on inst grant sram_en=1, sram_wen=0, sram_addr=inst_addr, sram_wdata=0. On data grant sram_en=1, sram_wen=data_wen, sram_addr=data_addr, sram_wdata=data_wdata. No grant: sram_en=0, sram_wen=0, addr/wdata=0.
- Owner register (response FSM), updated every edge: NONE / INST / DATA_RD / DATA_WR from this cycle's grant (DATA_WR when data_wen!=0).
- Response, cycle N+1 after grant in cycle N (latency 1, throughput 1/cycle):
  - owner INST -> inst_rvalid=1, inst_rdata=sram_rdata.
  - owner DATA_RD -> data_rvalid=1, data_rdata=sram_rdata.
  - owner DATA_WR -> data_rvalid=1, data_rdata=0.
  - owner NONE -> both rvalid 0.
  - rdata outputs pass through sram_rdata combinationally when the owner matches, else 0. Requester captures in the valid cycle; there is no holding.
- Back-to-back: a new grant in cycle N+1 is legal while the cycle-N response returns; the owner pipeline keeps them ordered.
- Starve counter (4-bit): increments on data grant while inst_req=1. Clears on inst grant or when inst_req=0. Saturates at STARVE_MAX.
- Requester dropping req before gnt: allowed, no side effect. Changing addr while req high and not granted: illegal (bench assertion).

Test Plan:
- Reset mid-op: inst grant at cycle 5 then rst at cycle 5.5 -> inst_rvalid stays 0, all outputs 0 until release, first grant on the first edge after release.
- Lone fetch stream: inst_req=1, addr 0x00,0x04,0x08 with sram_rdata mirroring mem -> inst_gnt every cycle, inst_rvalid each following cycle, rdata in order.
- Conflict, STARVE_MAX=4: both req held 10 cycles -> grant sequence D,D,D,D,I,D,D,D,D,I, no double grant.
- Store then load same address: data_wen=4'b0011, addr 0x100, wdata 0xAABBCCDD, then read 0x100 -> ack with data_rdata=0, then data_rdata=0x????CCDD from the SRAM model.
- Interleaved: data read at N, fetch at N+1 -> data_rvalid at N+1 and inst_rvalid at N+2, each with its own SRAM word, no cross-steering.
- Idle: no requests -> sram_en=0, both rvalid 0, starve_cnt stays 0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Arbitrates one synchronous single-port SRAM between instruction fetch and data access.
// Data wins conflicts; fetch is forced through after STARVE_MAX consecutive data wins.
module sram_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_INST    = 2'd1,
    OWN_DATA_RD = 2'd2,
    OWN_DATA_WR = 2'd3
  } owner_t;

  owner_t     owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  logic       force_inst;

  // Grants are gated by rst so nothing reaches the SRAM while reset is held.
  always_comb begin
    force_inst = (starve_q == STARVE_LIM);
    inst_gnt   = ~rst & inst_req & (~data_req | force_inst);
    data_gnt   = ~rst & data_req & ~(inst_req & force_inst);
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = 4'b0000;
    sram_addr  = 32'd0;
    sram_wdata = 32'd0;
    if (inst_gnt) begin
      sram_en   = 1'b1;
      sram_addr = inst_addr;
    end else if (data_gnt) begin
      sram_en    = 1'b1;
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      starve_q <= 4'd0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    owner_d  = OWN_NONE;
    starve_d = starve_q;
    if (inst_gnt) begin
      owner_d = OWN_INST;
    end else if (data_gnt) begin
      owner_d = (data_wen != 4'b0000) ? OWN_DATA_WR : OWN_DATA_RD;
    end
    // Counts only data wins that actually made a waiting fetch wait.
    if (!inst_req || inst_gnt) begin
      starve_d = 4'd0;
    end else if (data_gnt && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    inst_rvalid = (owner_q == OWN_INST);
    data_rvalid = (owner_q == OWN_DATA_RD) || (owner_q == OWN_DATA_WR);
    inst_rdata  = (owner_q == OWN_INST)    ? sram_rdata : 32'd0;
    data_rdata  = (owner_q == OWN_DATA_RD) ? sram_rdata : 32'd0;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed + randomized bench for sram_port_arbiter against a cycle-level
// transaction model with its own copy of memory contents.
module tb_sram_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  sram_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_gnt   (inst_gnt),
    .inst_rvalid(inst_rvalid),
    .inst_rdata (inst_rdata),
    .data_req   (data_req),
    .data_wen   (data_wen),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_gnt   (data_gnt),
    .data_rvalid(data_rvalid),
    .data_rdata (data_rdata),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seed(int i);
    return (i * 32'h9E3779B9) ^ 32'h0BADF00D;
  endfunction

  // SRAM environment: one-cycle read latency, byte-masked writes.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed(i);
    end else if (sram_en) begin
      sram_rdata <= mem[sram_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (sram_wen[b]) mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [0:255];
  int          m_starve;
  logic        exp_irv, exp_drv;
  logic [31:0] exp_ird, exp_drd;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_starve = 0;
    exp_irv  = 1'b0;
    exp_drv  = 1'b0;
    exp_ird  = 32'd0;
    exp_drd  = 32'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance model.
  task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
                       output logic gi, output logic gd);
    logic ei, ed;
    inst_req = ir; inst_addr = ia;
    data_req = dr; data_wen = dw; data_addr = da; data_wdata = dd;
    @(negedge clk);
    ei = ir && (!dr || m_starve == STARVE_MAX);
    ed = dr && !ei;
    chk("inst_gnt", inst_gnt, ei);
    chk("data_gnt", data_gnt, ed);
    chk("sram_en", sram_en, ei | ed);
    chk("sram_wen", sram_wen, ed ? dw : 4'd0);
    chk("sram_addr", sram_addr, ei ? ia : (ed ? da : 32'd0));
    chk("sram_wdata", sram_wdata, ed ? dd : 32'd0);
    chk("inst_rvalid", inst_rvalid, exp_irv);
    chk("inst_rdata", inst_rdata, exp_ird);
    chk("data_rvalid", data_rvalid, exp_drv);
    chk("data_rdata", data_rdata, exp_drd);
    $display("cyc t=%0t ireq=%0b dreq=%0b wen=%h gnt_i=%0b gnt_d=%0b irv=%0b drv=%0b",
             $time, ir, dr, dw, inst_gnt, data_gnt, inst_rvalid, data_rvalid);
    exp_irv = ei;
    exp_ird = ei ? ref_mem[ia[9:2]] : 32'd0;
    exp_drv = ed;
    exp_drd = (ed && dw == 4'd0) ? ref_mem[da[9:2]] : 32'd0;
    if (ed)
      for (int b = 0; b < 4; b++)
        if (dw[b]) ref_mem[da[9:2]][8*b +: 8] = dd[8*b +: 8];
    if (!ir || ei) m_starve = 0;
    else if (ed && m_starve < STARVE_MAX) m_starve++;
    gi = ei;
    gd = ed;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] raddr();
    logic [7:0] w;
    w = 8'($urandom_range(0, 255));
    return {22'd0, w, 2'b00};
  endfunction

  initial begin
    logic gi, gd;
    logic ir, dr;
    logic [3:0] dw;
    logic [31:0] ia, da, dd;

    rst = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h40;
    data_req = 1'b1; data_wen = 4'hF; data_addr = 32'h80; data_wdata = 32'h1234_5678;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    // Reset held with requests present: nothing granted, nothing driven.
    chk("rst_inst_gnt", inst_gnt, 1'b0);
    chk("rst_data_gnt", data_gnt, 1'b0);
    chk("rst_sram_en", sram_en, 1'b0);
    chk("rst_sram_wen", sram_wen, 4'd0);
    chk("rst_inst_rvalid", inst_rvalid, 1'b0);
    chk("rst_data_rvalid", data_rvalid, 1'b0);
    rst = 1'b0;
    model_reset();

    // Reset mid-operation: fetch granted, reset asserted half a cycle later.
    cycle(1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, gi, gd);
    inst_req = 1'b1; inst_addr = 32'h20; data_req = 1'b0;
    @(negedge clk);
    chk("mid_gnt_before_rst", inst_gnt, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("mid_gnt_in_rst", inst_gnt, 1'b0);
    chk("mid_sram_en_in_rst", sram_en, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_rvalid_dropped", inst_rvalid, 1'b0);
    chk("mid_rdata_dropped", inst_rdata, 32'd0);
    rst = 1'b0;
    model_reset();
    cycle(1'b1, 32'h20, 1'b0, 4'd0, 32'd0, 32'd0, gi, gd);
    chk("post_rst_first_gnt", gi, 1'b1);

    // Lone fetch stream.
    cycle(1'b1, 32'h00, 1'b0, 4'd0, 32'd0, 32'd0, gi, gd);
    cycle(1'b1, 32'h04, 1'b0, 4'd0, 32'd0, 32'd0, gi, gd);
    cycle(1'b1, 32'h08, 1'b0, 4'd0, 32'd0, 32'd0, gi, gd);
    cycle(1'b0, 32'h00, 1'b0, 4'd0, 32'd0, 32'd0, gi, gd);

    // Conflict: both held, fetch forced through every STARVE_MAX+1 cycles.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'h44, 1'b1, 4'd0, 32'(i * 4 + 32'h200), 32'd0, gi, gd);
      chk("conflict_seq_inst", gi, (i % 5) == 4);
      chk("conflict_no_double", gi & gd, 1'b0);
    end

    // Store then load of the same word.
    cycle(1'b0, 32'd0, 1'b1, 4'b0011, 32'h100, 32'hAABBCCDD, gi, gd);
    cycle(1'b0, 32'd0, 1'b1, 4'b0000, 32'h100, 32'd0, gi, gd);
    chk("load_low_half", data_rdata[15:0], 16'hCCDD);
    chk("load_high_half", data_rdata[31:16], seed(64) >> 16);
    cycle(1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, gi, gd);

    // Interleaved data read then fetch.
    cycle(1'b0, 32'd0, 1'b1, 4'd0, 32'h1F0, 32'd0, gi, gd);
    cycle(1'b1, 32'h0F0, 1'b0, 4'd0, 32'd0, 32'd0, gi, gd);
    cycle(1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, gi, gd);

    // Idle: counter must stay clear, so the first conflict goes to data.
    repeat (4) cycle(1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, gi, gd);
    cycle(1'b1, 32'h10, 1'b1, 4'd0, 32'h14, 32'd0, gi, gd);
    chk("idle_then_conflict_data", gd, 1'b1);
    cycle(1'b1, 32'h10, 1'b0, 4'd0, 32'd0, 32'd0, gi, gd);

    // Randomized traffic; a request stays stable until it is granted.
    ir = 1'b0; dr = 1'b0; ia = 32'd0; da = 32'd0; dw = 4'd0; dd = 32'd0;
    for (int n = 0; n < 400; n++) begin
      if (!ir) begin
        ir = ($urandom_range(0, 9) < 6);
        ia = raddr();
      end
      if (!dr) begin
        dr = ($urandom_range(0, 9) < 7);
        da = raddr();
        dw = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        dd = $urandom;
      end
      cycle(ir, ia, dr, dw, da, dd, gi, gd);
      if (gi) ir = 1'b0;
      if (gd) dr = 1'b0;
    end
    cycle(1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, gi, gd);
    cycle(1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, gi, gd);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
